// File: rtl/ofm_pkg.sv
// Shared types and constants for the OFM read-back path.
package ofm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFlush,
    StFin
  } state_e;

  localparam int unsigned FifoDepth = 3;
  localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

  // Bank index width; a single bank still needs one bit.
  function automatic int unsigned bank_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofm_drain_fifo.sv
// Three-entry output FIFO; pushes accepted when full only if the head pops in the same cycle.
module ofm_drain_fifo
  import ofm_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [Width-1:0]    wdata_i,
  output logic [Width-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [FifoCntW-1:0] cnt_o
);

  typedef logic [FifoCntW-1:0] ptr_t;

  logic [Width-1:0] mem_q [FifoDepth];
  ptr_t             wr_ptr_q, rd_ptr_q, cnt_q;
  logic             do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FifoDepth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == ptr_t'(FifoDepth));
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rdata_o = mem_q[rd_ptr_q];
    cnt_o   = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + ptr_t'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - ptr_t'(1);
    end
  end

endmodule

// File: rtl/ofm_drain.sv
// Reads all OFM banks address-major and serialises the words onto a valid/ready stream.
module ofm_drain
  import ofm_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 7
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [AW-1:0]         count,
  output logic [N-1:0]          rdEn,
  output logic [AW-1:0]         rdAdr,
  input  logic [N*W-1:0]        rdData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [W-1:0]          outData,
  output logic [bank_w(N)-1:0]  outBank,
  output logic [AW-1:0]         outAdr,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BW   = bank_w(N);
  localparam int unsigned EntW = 1 + BW + AW + W;
  localparam logic [BW-1:0] LastBank = BW'(N - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d, adr_q, adr_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [1:0]      inflight_q, inflight_d;
  // Tag of the read issued last cycle, whose data is on rdData now.
  logic            pend_q, pend_last_q;
  logic [BW-1:0]   pend_bank_q;
  logic [AW-1:0]   pend_adr_q;

  logic                fifo_full, fifo_empty, pop, issue, last_issue, credit_ok;
  logic [FifoCntW-1:0] fifo_cnt;
  logic [W-1:0]        bank_word;
  logic [EntW-1:0]     head;

  always_comb begin
    credit_ok  = !fifo_full && (({1'b0, fifo_cnt} + {1'b0, inflight_q}) < 3'(FifoDepth));
    issue      = (state_q == StRead) && credit_ok;
    last_issue = (bank_q == LastBank) && (adr_q == cnt_q - AW'(1));
    pop        = outValid && outReady;
    rdEn       = '0;
    bank_word  = '0;
    for (int unsigned b = 0; b < N; b++) begin
      rdEn[b] = issue && (bank_q == BW'(b));
      if (pend_bank_q == BW'(b)) bank_word = rdData[b*W +: W];
    end
    rdAdr = adr_q;
    busy  = (state_q == StRead) || (state_q == StFlush);
    done  = (state_q == StFin);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    bank_d  = bank_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = count;
          adr_d   = '0;
          bank_d  = '0;
          state_d = (count == '0) ? StFin : StRead;
        end
      end
      StRead: begin
        if (issue) begin
          if (bank_q == LastBank) begin
            bank_d = '0;
            adr_d  = adr_q + AW'(1);
          end else begin
            bank_d = bank_q + BW'(1);
          end
          if (last_issue) state_d = StFlush;
        end
      end
      StFlush: begin
        // Leave as the final word transfers so done lands on the following cycle.
        if (inflight_q == '0 && (fifo_empty || (fifo_cnt == FifoCntW'(1) && pop))) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !pend_q) inflight_d = inflight_q + 2'd1;
    else if (!issue && pend_q) inflight_d = inflight_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      adr_q       <= '0;
      bank_q      <= '0;
      inflight_q  <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_bank_q <= '0;
      pend_adr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      bank_q     <= bank_d;
      inflight_q <= inflight_d;
      pend_q     <= issue;
      if (issue) begin
        pend_last_q <= last_issue;
        pend_bank_q <= bank_q;
        pend_adr_q  <= adr_q;
      end
    end
  end

  ofm_drain_fifo #(
    .Width (EntW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .push_i  (pend_q),
    .pop_i   (pop),
    .wdata_i ({pend_last_q, pend_bank_q, pend_adr_q, bank_word}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  assign outValid = !fifo_empty;
  assign {outLast, outBank, outAdr, outData} = head;

endmodule

// File: tb/tb_ofm_drain.sv
// Directed bench for ofm_drain: bank model returns 0x100*bank + adr one cycle after the strobe.
module tb_ofm_drain;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned BW = 2;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] bank;
    logic [AW-1:0] adr;
    logic [W-1:0]  data;
  } word_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] count = '0;
  logic          outReady = 1'b0;
  logic [N*W-1:0] rdData = '0;
  logic [N-1:0]  rdEn;
  logic [AW-1:0] rdAdr;
  logic          outValid, outLast, busy, done;
  logic [W-1:0]  outData;
  logic [BW-1:0] outBank;
  logic [AW-1:0] outAdr;

  int n_checks = 0;
  int n_pass   = 0;

  word_t got[$];
  int    done_cycle, last_cycle, first_rden, first_valid, max_out, issued, rden_early, done_cnt;
  bit    busy_seen, stall_bad, onehot_bad;

  always #5 clk = ~clk;

  ofm_drain #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
    .count    (count),
    .rdEn     (rdEn),
    .rdAdr    (rdAdr),
    .rdData   (rdData),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outBank  (outBank),
    .outAdr   (outAdr),
    .outLast  (outLast),
    .busy     (busy),
    .done     (done)
  );

  always @(posedge clk) begin
    for (int b = 0; b < N; b++) begin
      if (rdEn[b]) rdData[b*W +: W] <= W'(32'h100 * b) + W'(rdAdr);
    end
  end

  function automatic word_t exp_word(input int i, input int cnt);
    int a;
    int b;
    a = i / N;
    b = i % N;
    exp_word = {(a == cnt - 1) && (b == N - 1), BW'(b), AW'(a), W'(32'h100 * b + a)};
  endfunction

  // Runs one drain from cycle 0 (start) and records what the stream produced; no checking here.
  // mode 0: ready high, 1: ready on even cycles, 2: ready low until cycle 20, 3: second start.
  task automatic run_drain(input logic [AW-1:0] cnt, input int mode, input int limit);
    got.delete();
    done_cycle = -1; last_cycle = -1; first_rden = -1; first_valid = -1;
    max_out = 0; issued = 0; rden_early = 0; done_cnt = 0;
    busy_seen = 0; stall_bad = 0; onehot_bad = 0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (mode == 3 && c == 4);
      count = (c == 0) ? cnt : AW'(5);
      case (mode)
        1:       outReady = (c % 2 == 0);
        2:       outReady = (c >= 20);
        default: outReady = 1'b1;
      endcase
      @(negedge clk);
      if (rdEn != '0) begin
        issued++;
        if (first_rden < 0) first_rden = c;
        if (c < 20) rden_early++;
      end
      if ($countones(rdEn) > 1) onehot_bad = 1;
      if (issued - got.size() > max_out) max_out = issued - got.size();
      if (outValid && first_valid < 0) first_valid = c;
      if (mode == 2 && c >= 3 && c < 20 && !(outValid && outData == '0)) stall_bad = 1;
      if (busy) busy_seen = 1;
      if (outValid && outReady) begin
        got.push_back({outLast, outBank, outAdr, outData});
        if (outLast) last_cycle = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (rdEn !== '0) $display("FAIL reset_rdEn: got %h want 0", rdEn); else n_pass++;
    n_checks++; if (rdAdr !== '0) $display("FAIL reset_rdAdr: got %h want 0", rdAdr); else n_pass++;
    n_checks++; if (outValid !== 1'b0) $display("FAIL reset_outValid: got %b want 0", outValid); else n_pass++;
    n_checks++;
    if ({outLast, outBank, outAdr, outData} !== '0)
      $display("FAIL reset_head: got %h want 0", {outLast, outBank, outAdr, outData});
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    @(posedge clk); #1;
    rstN = 1'b1;
  endtask

  task automatic test_stream;
    run_drain(3, 0, 40);
    n_checks++; if (got.size() !== 12) $display("FAIL stream_len: got %0d want 12", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 12; i++) begin
      n_checks++;
      if (got[i] !== exp_word(i, 3)) $display("FAIL stream_word%0d: got %h want %h", i, got[i], exp_word(i, 3));
      else n_pass++;
    end
    n_checks++; if (first_rden !== 1) $display("FAIL stream_first_rden: got %0d want 1", first_rden); else n_pass++;
    n_checks++; if (first_valid !== 3) $display("FAIL stream_first_valid: got %0d want 3", first_valid); else n_pass++;
    n_checks++; if (last_cycle !== 14) $display("FAIL stream_last_cycle: got %0d want 14", last_cycle); else n_pass++;
    n_checks++; if (done_cycle !== 15) $display("FAIL stream_done_cycle: got %0d want 15", done_cycle); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL stream_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (max_out !== 3) $display("FAIL stream_outstanding: got %0d want 3", max_out); else n_pass++;
    n_checks++; if (busy_seen !== 1'b1) $display("FAIL stream_busy: got %b want 1", busy_seen); else n_pass++;
    n_checks++; if (onehot_bad !== 1'b0) $display("FAIL stream_onehot: got %b want 0", onehot_bad); else n_pass++;
  endtask

  task automatic test_toggle;
    run_drain(3, 1, 80);
    n_checks++; if (got.size() !== 12) $display("FAIL toggle_len: got %0d want 12", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 12; i++) begin
      n_checks++;
      if (got[i] !== exp_word(i, 3)) $display("FAIL toggle_word%0d: got %h want %h", i, got[i], exp_word(i, 3));
      else n_pass++;
    end
    n_checks++; if (max_out > 3) $display("FAIL toggle_outstanding: got %0d want <=3", max_out); else n_pass++;
    n_checks++;
    if (done_cycle < 0 || done_cycle !== last_cycle + 1)
      $display("FAIL toggle_done: got %0d want %0d", done_cycle, last_cycle + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    run_drain(3, 2, 80);
    n_checks++; if (rden_early !== 3) $display("FAIL bp_rden_pulses: got %0d want 3", rden_early); else n_pass++;
    n_checks++; if (stall_bad !== 1'b0) $display("FAIL bp_head_stable: got %b want 0", stall_bad); else n_pass++;
    n_checks++; if (got.size() !== 12) $display("FAIL bp_len: got %0d want 12", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 12; i++) begin
      n_checks++;
      if (got[i] !== exp_word(i, 3)) $display("FAIL bp_word%0d: got %h want %h", i, got[i], exp_word(i, 3));
      else n_pass++;
    end
  endtask

  task automatic test_zero;
    run_drain(0, 0, 20);
    n_checks++; if (done_cycle !== 1) $display("FAIL zero_done_cycle: got %0d want 1", done_cycle); else n_pass++;
    n_checks++; if (first_valid !== -1) $display("FAIL zero_valid: got %0d want -1", first_valid); else n_pass++;
    n_checks++; if (issued !== 0) $display("FAIL zero_rden: got %0d want 0", issued); else n_pass++;
    n_checks++; if (busy_seen !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy_seen); else n_pass++;
  endtask

  task automatic test_restart;
    run_drain(1, 3, 40);
    n_checks++; if (got.size() !== 4) $display("FAIL restart_len: got %0d want 4", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++;
      if (got[i] !== exp_word(i, 1)) $display("FAIL restart_word%0d: got %h want %h", i, got[i], exp_word(i, 1));
      else n_pass++;
    end
    n_checks++; if (done_cycle !== 7) $display("FAIL restart_done_cycle: got %0d want 7", done_cycle); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_drain;
    @(posedge clk); #1;
    start = 1'b1; count = 3; outReady = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0; count = 5;
    end
    @(negedge clk);
    n_checks++; if (rdEn === '0) $display("FAIL mid_rden_active: got %h want nonzero", rdEn); else n_pass++;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    n_checks++; if (rdEn !== '0) $display("FAIL mid_rst_rdEn: got %h want 0", rdEn); else n_pass++;
    n_checks++; if (outValid !== 1'b0) $display("FAIL mid_rst_outValid: got %b want 0", outValid); else n_pass++;
    n_checks++;
    if ({outLast, outBank, outAdr, outData, rdAdr} !== '0)
      $display("FAIL mid_rst_fields: got %h want 0", {outLast, outBank, outAdr, outData, rdAdr});
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", done); else n_pass++;
    @(posedge clk); #1;
    rstN = 1'b1;
    run_drain(2, 0, 40);
    n_checks++; if (got.size() !== 8) $display("FAIL mid_redrain_len: got %0d want 8", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_checks++;
      if (got[i] !== exp_word(i, 2)) $display("FAIL mid_redrain_word%0d: got %h want %h", i, got[i], exp_word(i, 2));
      else n_pass++;
    end
    n_checks++;
    if (done_cycle < 0 || done_cycle !== last_cycle + 1)
      $display("FAIL mid_redrain_done: got %0d want %0d", done_cycle, last_cycle + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_backpressure();
    test_zero();
    test_restart();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
